// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned BAUD         = 115200;
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;  // 434

  // One idle bit time between frames; watchdog allows a full 12-bit frame time.
  localparam int unsigned DEF_GAP_CYCLES     = CLKS_PER_BIT;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 12 * CLKS_PER_BIT;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone,
    StGap
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to index 0.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  logic             hit_hi;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  assign any_valid = |req;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    hit_hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i >= int'(ptr)) begin
          hit_hi = 1'b1;
          idx_hi = IDX_W'(i);
        end
        idx_lo = IDX_W'(i);
      end
    end
  end

  // Nothing at or above ptr means the search wrapped to the lowest set bit.
  always_comb begin
    idx        = hit_hi ? idx_hi : idx_lo;
    grant      = '0;
    grant[idx] = any_valid;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one byte UART transmitter among N_REQ producers.
// Frame sequence: grant/capture, start pulse, wait for tx_done, inter-frame gap.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk_50M,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_done,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [GAP_W-1:0] gap_cnt;

  logic [N_REQ-1:0] sel_grant;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [7:0]       sel_byte;
  logic [IDX_W-1:0] next_ptr;
  logic             frame_end;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (sel_grant),
    .idx       (sel_idx),
    .any_valid (sel_any)
  );

  // One-hot byte mux driven by the arbiter grant.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_grant[i]) sel_byte = req_data[8*i +: 8];
    end
  end

  assign next_ptr = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  // A tx_done arriving on the limit cycle takes precedence over the watchdog.
  assign to_hit = (state == StWaitDone) && !tx_done &&
                  ((32'(to_cnt) + 32'd1) >= TIMEOUT_CYCLES);

  // WAIT_DONE cycle counter; held at zero in every other state so entry clears it.
  always_ff @(posedge clk_50M) begin
    if (rst || (state != StWaitDone)) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit;
      if (!to_hit) to_cnt <= to_cnt + 1'b1;
    end
  end

  assign frame_end = tx_done | to_hit;
`else
  logic unused_timeout_cfg;

  // Without the watchdog the limit has no meaning.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
  assign frame_end          = tx_done;
`endif

  // Frame sequencer with registered handshake and transmitter outputs.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state     <= StIdle;
      ptr       <= '0;
      gap_cnt   <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      req_ready <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      tx_start  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (sel_any) begin
            tx_data   <= sel_byte;
            grant_id  <= sel_idx;
            req_ready <= sel_grant;
            ptr       <= next_ptr;
            busy      <= 1'b1;
            state     <= StLaunch;
          end
        end
        StLaunch: begin
          tx_start <= 1'b1;
          state    <= StWaitDone;
        end
        StWaitDone: begin
          if (frame_end) begin
            if (GAP_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= StIdle;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= StGap;
            end
          end
        end
        StGap: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a timeline-based reference model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 434;
  localparam int TO  = 5208;

  logic             clk_50M   = 1'b0;
  logic             rst       = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data  = '0;
  logic             tx_done   = 1'b0;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic [1:0]       grant_id;
  logic             busy;
  logic             timeout_err;

  always #10 clk_50M = ~clk_50M;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frame timeline in absolute cycle numbers.
  bit           m_busy    = 1'b0;
  bit           m_waiting = 1'b0;
  int           m_ptr     = 0;
  int           launch_at = -1;
  int           idle_at   = -1;
  int           wait_from = -1;
  logic [N-1:0] exp_ready;
  logic         exp_start;
  logic         exp_to;
  logic [7:0]   exp_data  = '0;
  int           exp_gid   = 0;

  // Requester and transmitter stimulus state.
  bit [N-1:0]   pend = '0;
  logic [7:0]   req_byte [N];
  int           done_at    = -1;
  int           tx_delay   = 10;
  bit           rand_delay = 1'b0;
  bit           tx_mute    = 1'b0;
  bit           stray_en   = 1'b0;
  bit           rand_req   = 1'b0;
  bit           d_sched    = 1'b0;

  // Observed DUT events.
  int grant_log[$];
  int grant_cyc[$];
  int start_cyc[$];
  int data_log[$];
  int done_real  = -1;
  int busy_fall  = -1;
  int to_cyc     = -1;
  int to_count   = 0;
  bit prev_busy  = 1'b0;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int qget(int q[$], int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int rr_pick(bit [N-1:0] v, int from);
    for (int k = 0; k < N; k++) begin
      if (v[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // Expected outputs after the current edge, given the inputs sampled at it.
  function automatic void model_edge(logic [N-1:0] v, logic [8*N-1:0] dv, logic d, logic r);
    int g;
    exp_ready = '0;
    exp_start = 1'b0;
    exp_to    = 1'b0;
    if (r) begin
      m_busy    = 1'b0;
      m_waiting = 1'b0;
      m_ptr     = 0;
      launch_at = -1;
      idle_at   = -1;
      exp_data  = '0;
      exp_gid   = 0;
      return;
    end
    if (!m_busy) begin
      if (v != '0) begin
        g            = rr_pick(v, m_ptr);
        exp_ready[g] = 1'b1;
        exp_data     = dv[8*g +: 8];
        exp_gid      = g;
        m_ptr        = (g + 1) % N;
        m_busy       = 1'b1;
        launch_at    = cyc + 1;
        idle_at      = -1;
      end
    end else if (cyc == launch_at) begin
      exp_start = 1'b1;
      m_waiting = 1'b1;
      wait_from = cyc;
    end else if (m_waiting) begin
      if (d) begin
        m_waiting = 1'b0;
        idle_at   = cyc + GAP;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (cyc - wait_from == TO) begin
        exp_to    = 1'b1;
        m_waiting = 1'b0;
        idle_at   = cyc + GAP;
      end
`endif
    end
    if (m_busy && !m_waiting && cyc == idle_at) m_busy = 1'b0;
  endfunction

  task automatic drive_inputs();
    req_valid = pend;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = req_byte[i];
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    start_cyc.delete();
    data_log.delete();
    done_real = -1;
    busy_fall = -1;
    to_cyc    = -1;
    to_count  = 0;
  endtask

  task automatic step();
    logic [N-1:0]   v;
    logic [8*N-1:0] dv;
    logic           d;
    logic           r;
    logic           ds;
    v  = req_valid;
    dv = req_data;
    d  = tx_done;
    r  = rst;
    ds = d_sched;
    @(posedge clk_50M);
    #1;
    cyc++;
    model_edge(v, dv, d, r);
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("tx_start", 32'(tx_start), 32'(exp_start));
    check_eq("tx_data", 32'(tx_data), 32'(exp_data));
    check_eq("grant_id", 32'(grant_id), 32'(exp_gid));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("timeout_err", 32'(timeout_err), 32'(exp_to));
    if (|req_ready === 1'b1) begin
      grant_log.push_back(int'(grant_id));
      grant_cyc.push_back(cyc);
    end
    if (tx_start === 1'b1) begin
      start_cyc.push_back(cyc);
      data_log.push_back(int'(tx_data));
    end
    if (prev_busy && busy === 1'b0) busy_fall = cyc;
    prev_busy = (busy === 1'b1);
    if (timeout_err === 1'b1) begin
      to_cyc = cyc;
      to_count++;
    end
    if (d && ds && !r) done_real = cyc;
    // Requesters drop a byte once it is acknowledged.
    pend &= ~exp_ready;
    if (rand_req) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 99) < 3) begin
            pend[i]     = 1'b1;
            req_byte[i] = 8'($urandom);
          end
        end else if ($urandom_range(0, 999) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end
    // Transmitter: answer each start after tx_delay cycles.
    if (exp_start && !tx_mute) begin
      if (rand_delay) tx_delay = $urandom_range(1, 60);
      done_at = cyc + tx_delay;
    end
    d_sched = (done_at == cyc + 1);
    tx_done = d_sched || (stray_en && !m_waiting && $urandom_range(0, 19) == 0);
    drive_inputs();
  endtask

  task automatic run_until_idle(int budget, string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while ((m_busy || pend != '0) && k < budget);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t_req;
    for (int i = 0; i < N; i++) req_byte[i] = '0;

    // Reset
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // 1: single request, transmitter answers after 100 cycles
    clear_logs();
    tx_delay    = 100;
    pend        = 4'b0001;
    req_byte[0] = 8'h41;
    drive_inputs();
    t_req = cyc + 1;
    run_until_idle(2000, "t1");
    check_eq("t1_grant_edge", qget(grant_cyc, 0), t_req);
    check_eq("t1_start_lat", qget(start_cyc, 0) - qget(grant_cyc, 0), 1);
    check_eq("t1_gid", qget(grant_log, 0), 0);
    check_eq("t1_data", qget(data_log, 0), 32'h41);
    check_eq("t1_done_lat", done_real - qget(start_cyc, 0), 100);
    check_eq("t1_gap", busy_fall - done_real, GAP);

    // 2: all four valid after reset, strict rotation and frame spacing
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_logs();
    tx_delay = 51;
    pend     = 4'b1111;
    for (int i = 0; i < N; i++) req_byte[i] = 8'((i + 1) * 16);
    drive_inputs();
    run_until_idle(4000, "t2");
    for (int i = 0; i < N; i++) begin
      check_eq("t2_data_order", qget(data_log, i), (i + 1) * 16);
      check_eq("t2_gid_order", qget(grant_log, i), i);
    end
    for (int i = 0; i < N - 1; i++) begin
      check_eq("t2_spacing", qget(start_cyc, i + 1) - qget(start_cyc, i), 51 + GAP + 2);
    end

    // 3: after granting 2, requesters 0 and 3 together -> 3 first
    clear_logs();
    tx_delay    = 20;
    pend        = 4'b0100;
    req_byte[2] = 8'h33;
    drive_inputs();
    repeat (3) step();
    pend        = pend | 4'b1001;
    req_byte[0] = 8'h0a;
    req_byte[3] = 8'hd3;
    drive_inputs();
    run_until_idle(3000, "t3");
    check_eq("t3_first", qget(grant_log, 0), 2);
    check_eq("t3_second", qget(grant_log, 1), 3);
    check_eq("t3_third", qget(grant_log, 2), 0);

    // 4: tx_done in IDLE and (randomly) in LAUNCH/GAP is ignored
    clear_logs();
    tx_delay = 30;
    tx_done  = 1'b1;
    step();
    tx_done = 1'b1;
    step();
    check_eq("t4_idle_no_start", start_cyc.size(), 0);
    stray_en    = 1'b1;
    pend        = 4'b0010;
    req_byte[1] = 8'h7e;
    drive_inputs();
    run_until_idle(2000, "t4");
    stray_en = 1'b0;
    check_eq("t4_one_start", start_cyc.size(), 1);
    check_eq("t4_gap", busy_fall - done_real, GAP);

    // 5: reset during WAIT_DONE, stray done later, pointer restarts at 0
    clear_logs();
    tx_delay    = 80;
    pend        = 4'b0010;
    req_byte[1] = 8'h55;
    drive_inputs();
    for (int k = 0; k < 20 && !m_waiting; k++) step();
    repeat (10) step();
    check_eq("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_data", 32'(tx_data), 32'd0);
    check_eq("t5_rst_gid", 32'(grant_id), 32'd0);
    repeat (100) step();
    check_eq("t5_stray_idle", 32'(busy), 32'd0);
    check_eq("t5_no_extra_start", start_cyc.size(), 1);
    pend        = 4'b1010;
    req_byte[1] = 8'h11;
    req_byte[3] = 8'h33;
    drive_inputs();
    run_until_idle(2000, "t5");
    check_eq("t5_ptr_restart", qget(grant_log, 1), 1);
    check_eq("t5_then_3", qget(grant_log, 2), 3);

    // 6: transmitter never answers
    clear_logs();
    tx_mute     = 1'b1;
    pend        = 4'b0001;
    req_byte[0] = 8'h66;
    drive_inputs();
`ifdef UART_ARB_TIMEOUT_EN
    repeat (100) step();
    pend        = pend | 4'b0100;
    req_byte[2] = 8'h77;
    drive_inputs();
    for (int k = 0; k < 6000 && to_count == 0; k++) step();
    tx_mute  = 1'b0;
    tx_delay = 10;
    run_until_idle(2000, "t6");
    check_eq("t6_timeout_at", to_cyc - qget(start_cyc, 0), TO);
    check_eq("t6_pulses", to_count, 1);
    check_eq("t6_regrant", qget(grant_cyc, 1) - to_cyc, GAP + 1);
    check_eq("t6_regrant_id", qget(grant_log, 1), 2);
`else
    repeat (6000) step();
    check_eq("t6_stuck_busy", 32'(busy), 32'd1);
    check_eq("t6_no_timeout", to_count, 0);
    check_eq("t6_one_start", start_cyc.size(), 1);
    rst = 1'b1;
    step();
    rst     = 1'b0;
    tx_mute = 1'b0;
`endif

    // 7: randomized traffic with random latency and stray tx_done
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_logs();
    rand_req   = 1'b1;
    rand_delay = 1'b1;
    stray_en   = 1'b1;
    repeat (20000) step();
    rand_req = 1'b0;
    stray_en = 1'b0;
    run_until_idle(3000, "t7");
    check_eq("t7_frames", 32'(start_cyc.size() > 20), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
